// File: rtl/spiox.sv
// spiox: Wishbone LED/button peripheral; bus ack 1 clk after strobe, never stalls.
// Buttons debounce in 2+DB_CYCLES clks; SPIOX_PWM_EN adds PWM dimming of the LEDs.
module spiox #(
    parameter int NLED      = 4,
    parameter int NBTN      = 4,
    parameter int DB_CYCLES = 16,
    parameter int PWM_BITS  = 8
) (
    input  logic            i_clk,
    input  logic            i_areset_n,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [1:0]      i_wb_addr,
    input  logic [31:0]     i_wb_data,
    input  logic [3:0]      i_wb_sel,
    output logic            o_wb_stall,
    output logic            o_wb_ack,
    output logic [31:0]     o_wb_data,
    input  logic [NBTN-1:0] i_btn,
    output logic [NLED-1:0] o_led,
    output logic            o_int
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic            w_stb;
    logic            w_wr;
    logic [31:0]     w_rd;
    logic [NBTN-1:0] w_db_upd;
    logic [NBTN-1:0] w_rise;
    logic [NBTN-1:0] w_w1c;
    logic            w_unused;

    logic [NLED-1:0] r_led;
    logic [NBTN-1:0] r_sync1;
    logic [NBTN-1:0] r_sync2;
    logic [NBTN-1:0] r_db;
    logic [NBTN-1:0] r_ev;
    logic [NBTN-1:0] r_ien;
    logic [CW-1:0]   r_cnt [NBTN];
    logic            r_ack;
    logic [31:0]     r_rdat;
    logic            r_int;

    assign w_stb      = i_wb_cyc & i_wb_stb;
    assign w_wr       = w_stb & i_wb_we;
    assign w_unused   = ^{i_wb_sel, i_wb_data};
    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = r_ack;
    assign o_wb_data  = r_rdat;
    assign o_int      = r_int;

    // A debounced level flips only once the mismatch has persisted DB_CYCLES clocks.
    always_comb begin
        w_db_upd = '0;
        for (int k = 0; k < NBTN; k++) begin
            w_db_upd[k] = (r_sync2[k] != r_db[k]) && (r_cnt[k] == DB_LAST);
        end
    end

    assign w_rise = w_db_upd & r_sync2;
    assign w_w1c  = (w_wr && (i_wb_addr == 2'd1)) ? i_wb_data[NBTN+7:8] : '0;

`ifdef SPIOX_PWM_EN
    logic [PWM_BITS-1:0] r_pc;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] r_duty_wr;
    logic [NLED-1:0]     r_led_out;
    logic                w_duty_we;

    assign w_duty_we = w_wr && (i_wb_addr == 2'd3);

    // The active duty only changes at the counter wrap so a period is never split.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_pc      <= '0;
            r_duty    <= '1;
            r_duty_wr <= '1;
            r_led_out <= '0;
        end else begin
            r_pc <= r_pc + 1'b1;
            if (w_duty_we) begin
                r_duty_wr <= i_wb_data[PWM_BITS-1:0];
            end
            if (r_pc == '1) begin
                r_duty <= w_duty_we ? i_wb_data[PWM_BITS-1:0] : r_duty_wr;
            end
            r_led_out <= r_led & {NLED{r_pc < r_duty}};
        end
    end

    assign o_led = r_led_out;
`else
    localparam int unused_pwm_bits = PWM_BITS;
    assign o_led = r_led;
`endif

    always_comb begin
        w_rd = '0;
        case (i_wb_addr)
            2'd0: w_rd[NLED-1:0] = r_led;
            2'd1: begin
                w_rd[NBTN-1:0]   = r_db;
                w_rd[NBTN+7:8]   = r_ev;
            end
            2'd2: w_rd[NBTN-1:0] = r_ien;
`ifdef SPIOX_PWM_EN
            2'd3: w_rd[PWM_BITS-1:0] = r_duty_wr;
`endif
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_ack  <= 1'b0;
            r_rdat <= '0;
            r_led  <= '0;
            r_ien  <= '0;
        end else begin
            r_ack <= w_stb;
            if (w_stb) begin
                r_rdat <= w_rd;
            end
            if (w_wr && (i_wb_addr == 2'd0)) begin
                for (int k = 0; k < NLED; k++) begin
                    if (i_wb_data[k+8]) begin
                        r_led[k] <= i_wb_data[k];
                    end
                end
            end
            if (w_wr && (i_wb_addr == 2'd2)) begin
                r_ien <= i_wb_data[NBTN-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            for (int k = 0; k < NBTN; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            for (int k = 0; k < NBTN; k++) begin
                if ((r_sync2[k] == r_db[k]) || w_db_upd[k]) begin
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
                if (w_db_upd[k]) begin
                    r_db[k] <= r_sync2[k];
                end
            end
        end
    end

    // A new press beats a simultaneous clear so no event is ever lost.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_ev  <= '0;
            r_int <= 1'b0;
        end else begin
            r_ev  <= (r_ev & ~w_w1c) | w_rise;
            r_int <= |(r_ev & r_ien);
        end
    end

endmodule

// File: tb/tb_spiox.sv
// Directed bench for spiox: LED masking, debounce timing, events, interrupt, reset.
module tb_spiox;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = 4'hF;
    logic        stall;
    logic        ack;
    logic [31:0] rdat;
    logic [3:0]  btn = 4'h0;
    logic [3:0]  led;
    logic        intr;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    spiox #(.NLED(4), .NBTN(4), .DB_CYCLES(16), .PWM_BITS(8)) dut (
        .i_clk      (clk),
        .i_areset_n (rst_n),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_data  (wdat),
        .i_wb_sel   (sel),
        .o_wb_stall (stall),
        .o_wb_ack   (ack),
        .o_wb_data  (rdat),
        .i_btn      (btn),
        .o_led      (led),
        .o_int      (intr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                       output logic [31:0] r);
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("ack", {31'd0, ack}, 32'd1);
        r = rdat;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(1'b1, a, d, r);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, a, 32'd0, r);
        check(tag, r, exp);
    endtask

    initial begin
        int hi;

        // Reset state while reset is held
        #12;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_rdat", rdat, 32'd0);
        check("rst_led", {28'd0, led}, 32'd0);
        check("rst_int", {31'd0, intr}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        clks(1);
        rst_n = 1'b1;

        // Masked LED writes
        wr(2'd0, 32'h0000_0305);
        rd_chk("led_a", 2'd0, 32'h1);
        wr(2'd0, 32'h0000_0200);
        rd_chk("led_b", 2'd0, 32'h1);
        check("oled_b", {28'd0, led}, 32'h1);
        wr(2'd0, 32'h0000_0F0F);
        wr(2'd0, 32'h0000_0300);
        rd_chk("led_c", 2'd0, 32'hC);
        check("oled_c", {28'd0, led}, 32'hC);

        // Asynchronous reset with a read in flight
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; addr = 2'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_ack", {31'd0, ack}, 32'd0);
        check("mid_led", {28'd0, led}, 32'd0);
        check("mid_int", {31'd0, intr}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        clks(2);
        rst_n = 1'b1;
        rd_chk("post_led", 2'd0, 32'h0);
        rd_chk("post_btn", 2'd1, 32'h0);
        rd_chk("post_ien", 2'd2, 32'h0);
        rd_chk("post_r3", 2'd3, 32'h0);

        // Interrupt enable mask
        wr(2'd2, 32'hFFFF_FFFF);
        rd_chk("ien_all", 2'd2, 32'hF);
        wr(2'd2, 32'h1);
        rd_chk("ien_1", 2'd2, 32'h1);

        // 10-clock glitch is rejected
        btn = 4'h1;
        clks(10);
        btn = 4'h0;
        clks(30);
        rd_chk("glitch", 2'd1, 32'h0);
        check("glitch_int", {31'd0, intr}, 32'd0);

        // Held press: level and event appear 18 clocks after the raw edge
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 2'd1;
        btn = 4'h1;
        for (int i = 1; i <= 19; i++) begin
            @(posedge clk);
            #1;
            if (i == 18) begin
                check("db_pre", rdat, 32'h0);
                check("int_pre", {31'd0, intr}, 32'd0);
            end
            if (i == 19) begin
                check("db_18", rdat, 32'h101);
                check("int_set", {31'd0, intr}, 32'd1);
            end
        end
        cyc = 1'b0; stb = 1'b0;

        // W1C drops the interrupt
        wr(2'd1, 32'h100);
        clks(1);
        check("int_clr", {31'd0, intr}, 32'd0);
        rd_chk("w1c", 2'd1, 32'h1);

        // Masked button and release
        btn = 4'h3;
        clks(25);
        rd_chk("btn1", 2'd1, 32'h203);
        check("int_masked", {31'd0, intr}, 32'd0);
        btn = 4'h0;
        clks(25);
        rd_chk("release", 2'd1, 32'h200);
        wr(2'd1, 32'hF00);
        rd_chk("clr_all", 2'd1, 32'h0);

        // W1C on the same edge the event sets: set wins
        @(posedge clk);
        #1;
        btn = 4'h1;
        clks(17);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 2'd1; wdat = 32'h100;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("race_ack", {31'd0, ack}, 32'd1);
        rd_chk("race", 2'd1, 32'h101);
        check("race_int", {31'd0, intr}, 32'd1);

`ifdef SPIOX_PWM_EN
        wr(2'd3, 32'h55);
        rd_chk("r3", 2'd3, 32'h55);
        wr(2'd0, 32'h101);
        wr(2'd3, 32'h40);
        clks(300);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            hi += int'(led[0]);
        end
        check("pwm64", hi, 32'd64);
        wr(2'd3, 32'h0);
        clks(300);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            hi += int'(led[0]);
        end
        check("pwm0", hi, 32'd0);
`else
        hi = 0;
        wr(2'd3, 32'h55);
        rd_chk("r3", 2'd3, 32'h0);
        wr(2'd0, 32'h101);
        clks(2);
        check("oled_direct", {28'd0, led}, 32'h1 + 32'(hi));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
